stochastic_repl_sequencer: RTL and testbench

Command sequencer for the stochastic REPL core. Consumes received UART bytes, decodes single-letter REPL commands, loads probability registers driving the three SNGs, selects the arithmetic operation, and sequences one bitstream-to-binary conversion per run command. Returns acknowledgements or the 16-bit result as bytes to the UART transmitter. It sits between the UART RX/TX byte interfaces and the SNG/arithmetic/converter datapath.

---
 rtl/stochastic_repl_sequencer_pkg.sv | 50 +++++
 rtl/stochastic_repl_sequencer_if.sv | 33 +++
 rtl/stochastic_repl_sequencer_timeout_counter.sv | 36 +++
 rtl/stochastic_repl_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_stochastic_repl_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stochastic_repl_sequencer_pkg.sv
// stochastic_repl_pkg
// Shared definitions for the stochastic REPL command path: opcode and
// response byte values, sequencer state encoding, argument targets and the
// SNG probability reset defaults. No ports (package).
package stochastic_repl_pkg;

    localparam logic [7:0] OP_LOAD_A   = 8'h41;  // 'A'
    localparam logic [7:0] OP_LOAD_B   = 8'h42;  // 'B'
    localparam logic [7:0] OP_LOAD_C   = 8'h43;  // 'C'
    localparam logic [7:0] OP_SET_OP   = 8'h4F;  // 'O'
    localparam logic [7:0] OP_RUN      = 8'h52;  // 'R'

    localparam logic [7:0] RSP_ACK     = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

    localparam logic [7:0] PROB_A_RST  = 8'd128;
    localparam logic [7:0] PROB_B_RST  = 8'd64;
    localparam logic [7:0] PROB_C_RST  = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_SEND_ACK,
        ST_START,
        ST_WAIT_DONE,
        ST_SEND_HI,
        ST_SEND_LO
    } state_t;

    typedef enum logic [1:0] {
        TGT_A,
        TGT_B,
        TGT_C,
        TGT_OP
    } arg_target_t;

    // Maps an argument-taking opcode to the register its argument lands in.
    function automatic arg_target_t target_of(input logic [7:0] opcode);
        arg_target_t t;
        case (opcode)
            OP_LOAD_A: t = TGT_A;
            OP_LOAD_B: t = TGT_B;
            OP_LOAD_C: t = TGT_C;
            default:   t = TGT_OP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/stochastic_repl_sequencer_if.sv
// stochastic_repl_sequencer_if
// Byte-stream interface between the UART RX/TX and the REPL sequencer.
//   rx_data  [7:0]  received byte
//   rx_valid        one-cycle strobe, rx_data valid
//   tx_data  [7:0]  byte to transmit
//   tx_valid        tx_data valid, held until accepted
//   tx_ready        transmitter accepts on tx_valid & tx_ready
// master: UART side (drives rx, tx_ready); slave: sequencer side.
interface stochastic_repl_sequencer_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/stochastic_repl_sequencer_timeout_counter.sv
// repl_timeout_counter
// Conversion watchdog. Down-counter loaded with TIMEOUT_CYCLES-1 on clear,
// decremented while enabled, holding at zero. tc is high at zero, i.e. on
// the TIMEOUT_CYCLES-th enabled cycle after a clear.
//   clk, rst  clock, synchronous active-low reset
//   clear     reload the counter
//   enable    count down one step
//   tc        terminal count reached
module repl_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 131072
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= LOAD;
        end else if (clear) begin
            cnt_q <= LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/stochastic_repl_sequencer.sv
// stochastic_repl_sequencer
// Decodes single-letter REPL commands from the UART byte stream, loads the
// SNG probability / op-select registers, runs one bitstream-to-binary
// conversion per 'R' and returns 'K' / '?' / 'T' or the two result bytes.
//   clk, rst            clock, synchronous active-low reset
//   bus (slave)         rx byte strobe in, tx byte with valid/ready out
//   prob_a/b/control    SNG probabilities (value/256)
//   op_sel              0 = multiply, 1 = scaled add
//   start_conversion    one-cycle converter start
//   result_binary       converter result, valid with conversion_done
//   conversion_done     one-cycle converter completion
//   busy                high in START, WAIT_DONE and SEND_* states
//   error               sticky error, cleared by any decoded opcode
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | waiting for an opcode byte
// ST_GET_ARG   | waiting for the argument of A/B/C/O
// ST_SEND_ACK  | presenting a single response byte (K, ?, T)
// ST_START     | start_conversion pulse, watchdog reload
// ST_WAIT_DONE | waiting for conversion_done or watchdog expiry
// ST_SEND_HI   | presenting result[15:8]
// ST_SEND_LO   | presenting result[7:0]
module stochastic_repl_sequencer
    import stochastic_repl_pkg::*;
#(
    parameter int unsigned RESULT_W       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 131072
) (
    input  logic                 clk,
    input  logic                 rst,
    stochastic_repl_sequencer_if.slave bus,
    output logic [7:0]           prob_a,
    output logic [7:0]           prob_b,
    output logic [7:0]           prob_control,
    output logic                 op_sel,
    output logic                 start_conversion,
    input  logic [RESULT_W-1:0]  result_binary,
    input  logic                 conversion_done,
    output logic                 busy,
    output logic                 error
);

    state_t                state_q;
    arg_target_t           target_q;
    logic [RESULT_W-1:0]   result_q;
    logic [7:0]            prob_a_q;
    logic [7:0]            prob_b_q;
    logic [7:0]            prob_c_q;
    logic                  op_sel_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  error_q;

    logic                  tx_accept;
    logic                  tmo_tc;
    logic                  rx_unexpected;

    assign tx_accept     = tx_valid_q & bus.tx_ready;
    assign rx_unexpected = bus.rx_valid && (state_q != ST_IDLE) && (state_q != ST_GET_ARG);

    repl_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == ST_START),
        .enable (state_q == ST_WAIT_DONE),
        .tc     (tmo_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            target_q   <= TGT_A;
            result_q   <= '0;
            prob_a_q   <= PROB_A_RST;
            prob_b_q   <= PROB_B_RST;
            prob_c_q   <= PROB_C_RST;
            op_sel_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            OP_LOAD_A, OP_LOAD_B, OP_LOAD_C, OP_SET_OP: begin
                                target_q <= target_of(bus.rx_data);
                                error_q  <= 1'b0;
                                state_q  <= ST_GET_ARG;
                            end
                            OP_RUN: begin
                                error_q <= 1'b0;
                                start_q <= 1'b1;
                                busy_q  <= 1'b1;
                                state_q <= ST_START;
                            end
                            default: begin
                                error_q    <= 1'b1;
                                tx_data_q  <= RSP_UNKNOWN;
                                tx_valid_q <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= ST_SEND_ACK;
                            end
                        endcase
                    end
                end
                ST_GET_ARG: begin
                    if (bus.rx_valid) begin
                        case (target_q)
                            TGT_A:   prob_a_q <= bus.rx_data;
                            TGT_B:   prob_b_q <= bus.rx_data;
                            TGT_C:   prob_c_q <= bus.rx_data;
                            default: op_sel_q <= bus.rx_data[0];
                        endcase
                        tx_data_q  <= RSP_ACK;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SEND_ACK;
                    end
                end
                ST_SEND_ACK: begin
                    if (tx_accept) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A completion landing on the terminal-count cycle is honoured.
                    if (conversion_done) begin
                        result_q   <= result_binary;
                        tx_data_q  <= result_binary[15:8];
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND_HI;
                    end else if (tmo_tc) begin
                        tx_data_q  <= RSP_TIMEOUT;
                        tx_valid_q <= 1'b1;
                        error_q    <= 1'b1;
                        state_q    <= ST_SEND_ACK;
                    end
                end
                ST_SEND_HI: begin
                    if (tx_accept) begin
                        tx_data_q <= result_q[7:0];
                        state_q   <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (tx_accept) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Bytes arriving while the sequencer is occupied are discarded.
            if (rx_unexpected) begin
                error_q <= 1'b1;
            end
        end
    end

    assign prob_a           = prob_a_q;
    assign prob_b           = prob_b_q;
    assign prob_control     = prob_c_q;
    assign op_sel           = op_sel_q;
    assign start_conversion = start_q;
    assign busy             = busy_q;
    assign error            = error_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;

endmodule

// File: tb/tb_stochastic_repl_sequencer.sv
// Testbench for stochastic_repl_sequencer. Expected transmit bytes are queued
// as commands are issued; a monitor pops and compares on every accepted byte.
// The watchdog is shortened to 64 cycles so the timeout path runs quickly;
// converter latency is therefore kept below that.
module tb_stochastic_repl_sequencer;

    localparam int unsigned TMO = 64;

    logic        clk;
    logic        rst;
    logic [7:0]  prob_a;
    logic [7:0]  prob_b;
    logic [7:0]  prob_control;
    logic        op_sel;
    logic        start_conversion;
    logic [15:0] result_binary;
    logic        conversion_done;
    logic        busy;
    logic        error;

    stochastic_repl_sequencer_if bus ();

    stochastic_repl_sequencer #(
        .RESULT_W       (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .prob_a           (prob_a),
        .prob_b           (prob_b),
        .prob_control     (prob_control),
        .op_sel           (op_sel),
        .start_conversion (start_conversion),
        .result_binary    (result_binary),
        .conversion_done  (conversion_done),
        .busy             (busy),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_start  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: a byte is transferred on the edge following a
    // negedge where tx_valid & tx_ready are both high.
    always @(negedge clk) begin
        if (rst && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got %02h, expected no byte", bus.tx_data);
            end else begin
                check("sb_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (rst && start_conversion) n_start++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r);
        result_binary   = r;
        conversion_done = 1'b1;
        tick();
        conversion_done = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((busy || bus.tx_valid) && n < 500) begin
            tick();
            n++;
        end
        check(name, {31'h0, (n < 500)}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts0;
        rst             = 1'b0;
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.tx_ready    = 1'b1;
        result_binary   = 16'h0000;
        conversion_done = 1'b0;
        repeat (3) tick();
        check("rst_prob_a", {24'h0, prob_a}, 32'd128);
        check("rst_prob_b", {24'h0, prob_b}, 32'd64);
        check("rst_prob_c", {24'h0, prob_control}, 32'd128);
        check("rst_op_sel", {31'h0, op_sel}, 32'd0);
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
        check("rst_start", {31'h0, start_conversion}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_error", {31'h0, error}, 32'd0);
        rst = 1'b1;
        tick();

        // Load A
        exp_q.push_back(8'h4B);
        send_byte(8'h41);
        send_byte(8'h20);
        check("load_a_value", {24'h0, prob_a}, 32'h20);
        check("load_a_ack_valid", {31'h0, bus.tx_valid}, 32'd1);
        check("load_a_prob_b", {24'h0, prob_b}, 32'd64);
        check("load_a_error", {31'h0, error}, 32'd0);
        wait_quiet("load_a_quiet");

        // Op select
        exp_q.push_back(8'h4B);
        send_byte(8'h4F);
        send_byte(8'h01);
        check("op_sel_set", {31'h0, op_sel}, 32'd1);
        wait_quiet("op_quiet");

        // Run with immediate acceptance
        starts0 = n_start;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_byte(8'h52);
        check("run_start_hi", {31'h0, start_conversion}, 32'd1);
        check("run_busy_start", {31'h0, busy}, 32'd1);
        tick();
        check("run_start_lo", {31'h0, start_conversion}, 32'd0);
        repeat (20) tick();
        pulse_done(16'h1234);
        check("run_hi_valid", {31'h0, bus.tx_valid}, 32'd1);
        check("run_busy_hi", {31'h0, busy}, 32'd1);
        tick();
        check("run_busy_lo", {31'h0, busy}, 32'd1);
        tick();
        check("run_busy_drop", {31'h0, busy}, 32'd0);
        check("run_one_start", n_start - starts0, 32'd1);
        check("run_op_sel", {31'h0, op_sel}, 32'd1);
        check("run_sb_drain", exp_q.size(), 32'd0);

        // Run with transmitter stalled after done
        bus.tx_ready = 1'b0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hAB);
        send_byte(8'h52);
        repeat (10) tick();
        pulse_done(16'h12AB);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {31'h0, bus.tx_valid}, 32'd1);
            check("stall_data", {24'h0, bus.tx_data}, 32'h12);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_quiet("stall_quiet");
        check("stall_sb_drain", exp_q.size(), 32'd0);

        // Converter never answers
        starts0 = n_start;
        exp_q.push_back(8'h54);
        send_byte(8'h52);
        repeat (TMO) tick();
        check("tmo_not_early", {31'h0, bus.tx_valid}, 32'd0);
        check("tmo_busy", {31'h0, busy}, 32'd1);
        tick();
        check("tmo_valid", {31'h0, bus.tx_valid}, 32'd1);
        check("tmo_error", {31'h0, error}, 32'd1);
        wait_quiet("tmo_quiet");
        check("tmo_one_start", n_start - starts0, 32'd1);

        // Next opcode clears error
        exp_q.push_back(8'h4B);
        send_byte(8'h42);
        check("clr_error", {31'h0, error}, 32'd0);
        send_byte(8'h80);
        check("load_b_value", {24'h0, prob_b}, 32'h80);
        wait_quiet("load_b_quiet");

        // Done on the terminal-count cycle: result wins, no error
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h21);
        send_byte(8'h52);
        repeat (TMO) tick();
        pulse_done(16'h4321);
        check("tc_done_valid", {31'h0, bus.tx_valid}, 32'd1);
        check("tc_done_error", {31'h0, error}, 32'd0);
        wait_quiet("tc_quiet");
        check("tc_sb_drain", exp_q.size(), 32'd0);

        // Unknown opcode
        exp_q.push_back(8'h3F);
        send_byte(8'h5A);
        check("unk_error", {31'h0, error}, 32'd1);
        check("unk_valid", {31'h0, bus.tx_valid}, 32'd1);
        wait_quiet("unk_quiet");

        // Byte during WAIT_DONE is dropped; result still returned
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0E);
        send_byte(8'h52);
        check("drop_run_clr_err", {31'h0, error}, 32'd0);
        repeat (3) tick();
        send_byte(8'h41);
        check("drop_error", {31'h0, error}, 32'd1);
        check("drop_busy", {31'h0, busy}, 32'd1);
        check("drop_no_tx", {31'h0, bus.tx_valid}, 32'd0);
        repeat (3) tick();
        pulse_done(16'h0F0E);
        wait_quiet("drop_quiet");
        check("drop_prob_a", {24'h0, prob_a}, 32'h20);
        check("drop_error_sticky", {31'h0, error}, 32'd1);
        check("drop_sb_drain", exp_q.size(), 32'd0);

        // Reset during WAIT_DONE
        send_byte(8'h52);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_prob_a", {24'h0, prob_a}, 32'd128);
        check("mid_rst_prob_b", {24'h0, prob_b}, 32'd64);
        check("mid_rst_op_sel", {31'h0, op_sel}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        pulse_done(16'hDEAD);
        check("post_rst_done_tx", {31'h0, bus.tx_valid}, 32'd0);
        check("post_rst_done_busy", {31'h0, busy}, 32'd0);
        repeat (TMO + 8) tick();
        check("post_rst_no_tmo", {31'h0, bus.tx_valid}, 32'd0);
        check("final_sb_drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
